// File: rtl/rc_frame_ctrl.sv
// rtl/rc_frame_ctrl.sv - frame-level sequencer for the LCU rate-control unit
// Walks the CTU raster, serves per-CTU QP requests and updates the frame QP at frame end.
module rc_frame_ctrl #(
  parameter int PIC_X_WIDTH = 8,
  parameter int PIC_Y_WIDTH = 8,
  parameter int WDOG_MAX    = 31
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sys_start_i,
  input  logic [PIC_X_WIDTH-1:0] sys_ctu_all_x_i,
  input  logic [PIC_Y_WIDTH-1:0] sys_ctu_all_y_i,
  output logic                   sys_done_o,
  input  logic                   qp_req_i,
  output logic                   qp_vld_o,
  output logic [5:0]             qp_o,
  output logic                   rc_start_o,
  output logic [PIC_X_WIDTH-1:0] rc_ctu_x_o,
  output logic [PIC_Y_WIDTH-1:0] rc_ctu_y_o,
  input  logic                   rc_done_i,
  input  logic [5:0]             rc_qp_i,
  input  logic                   cabac_bit_vld_i,
  input  logic [15:0]            cabac_bitnum_i,
  input  logic [31:0]            reg_bitnum_i,
  input  logic [5:0]             reg_initial_qp,
  input  logic [5:0]             reg_max_qp,
  input  logic [5:0]             reg_min_qp,
  input  logic                   reg_frame_rc_en,
  output logic [5:0]             frame_qp_o,
  output logic [31:0]            frame_bits_o,
  output logic                   err_o
);

  localparam int WDW = $clog2(WDOG_MAX + 1);
  localparam int CW  = PIC_X_WIDTH + PIC_Y_WIDTH + 2;
  localparam logic [WDW-1:0] WDOG_LIM = WDW'(WDOG_MAX);

  typedef enum logic [2:0] {IDLE, WAIT_REQ, RC_RUN, WAIT_BITS, UPD} state_t;

  state_t                 state_q, state_d;
  logic [PIC_X_WIDTH-1:0] all_x_q, all_x_d, x_q, x_d;
  logic [PIC_Y_WIDTH-1:0] all_y_q, all_y_d, y_q, y_d;
  logic [WDW-1:0]         wdog_q, wdog_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [31:0]            frame_bits_q, frame_bits_d;
  logic [5:0]             frame_qp_q, frame_qp_d;
  logic [5:0]             qp_q, qp_d;
  logic                   qp_vld_q, qp_vld_d;
  logic                   rc_start_q, rc_start_d;
  logic                   sys_done_q, sys_done_d;
  logic                   err_q, err_d;
  logic                   first_q, first_d;

  logic [CW-1:0] ctu_total;
  logic [32:0]   bits_sum, hi_lim;
  logic [31:0]   lo_lim;
  logic [6:0]    qp_step, qp_clip;
  logic          last_ctu, timeout;

  assign ctu_total = ({{(CW-PIC_X_WIDTH){1'b0}}, all_x_q} + CW'(1)) *
                     ({{(CW-PIC_Y_WIDTH){1'b0}}, all_y_q} + CW'(1));
  assign bits_sum  = {1'b0, frame_bits_q} + {17'b0, cabac_bitnum_i};
  assign hi_lim    = {1'b0, reg_bitnum_i} + {4'b0, reg_bitnum_i[31:3]};
  assign lo_lim    = reg_bitnum_i - {3'b0, reg_bitnum_i[31:3]};
  assign last_ctu  = (x_q == all_x_q) && (y_q == all_y_q);
  assign timeout   = (wdog_q == WDOG_LIM);

  // Frame QP step is computed in 7 bits so +1 at 63 and the clip never wrap.
  always_comb begin
    qp_step = {1'b0, frame_qp_q};
    if (reg_frame_rc_en && ({1'b0, frame_bits_q} > hi_lim)) begin
      qp_step = qp_step + 7'd1;
    end else if (reg_frame_rc_en && (frame_bits_q < lo_lim) && (frame_qp_q != 6'd0)) begin
      qp_step = qp_step - 7'd1;
    end
    qp_clip = qp_step;
    if (qp_clip > {1'b0, reg_max_qp}) qp_clip = {1'b0, reg_max_qp};
    if (qp_clip < {1'b0, reg_min_qp}) qp_clip = {1'b0, reg_min_qp};
  end

  always_comb begin
    state_d      = state_q;
    all_x_d      = all_x_q;
    all_y_d      = all_y_q;
    x_d          = x_q;
    y_d          = y_q;
    wdog_d       = wdog_q;
    bit_cnt_d    = bit_cnt_q;
    frame_bits_d = frame_bits_q;
    frame_qp_d   = frame_qp_q;
    qp_d         = qp_q;
    qp_vld_d     = 1'b0;
    rc_start_d   = 1'b0;
    sys_done_d   = 1'b0;
    err_d        = err_q;
    first_d      = first_q;

    if ((state_q != IDLE) && cabac_bit_vld_i) begin
      frame_bits_d = bits_sum[32] ? 32'hFFFF_FFFF : bits_sum[31:0];
      bit_cnt_d    = bit_cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (sys_start_i) begin
          all_x_d      = sys_ctu_all_x_i;
          all_y_d      = sys_ctu_all_y_i;
          x_d          = '0;
          y_d          = '0;
          frame_bits_d = '0;
          bit_cnt_d    = '0;
          if (first_q || !reg_frame_rc_en) frame_qp_d = reg_initial_qp;
          first_d      = 1'b0;
          state_d      = WAIT_REQ;
        end
      end
      WAIT_REQ: begin
        // The request is still high in the cycle the previous QP is returned.
        if (qp_req_i && !qp_vld_q) begin
          rc_start_d = 1'b1;
          wdog_d     = '0;
          state_d    = RC_RUN;
        end
      end
      RC_RUN: begin
        if (rc_done_i || timeout) begin
          qp_vld_d = 1'b1;
          qp_d     = rc_done_i ? rc_qp_i : frame_qp_q;
          if (!rc_done_i) err_d = 1'b1;
          if (x_q == all_x_q) begin
            x_d = '0;
            y_d = y_q + PIC_Y_WIDTH'(1);
          end else begin
            x_d = x_q + PIC_X_WIDTH'(1);
          end
          state_d = last_ctu ? WAIT_BITS : WAIT_REQ;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      WAIT_BITS: begin
        if (bit_cnt_q == ctu_total) state_d = UPD;
      end
      UPD: begin
        frame_qp_d = qp_clip[5:0];
        sys_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      all_x_q      <= '0;
      all_y_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      wdog_q       <= '0;
      bit_cnt_q    <= '0;
      frame_bits_q <= '0;
      frame_qp_q   <= '0;
      qp_q         <= '0;
      qp_vld_q     <= 1'b0;
      rc_start_q   <= 1'b0;
      sys_done_q   <= 1'b0;
      err_q        <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      all_x_q      <= all_x_d;
      all_y_q      <= all_y_d;
      x_q          <= x_d;
      y_q          <= y_d;
      wdog_q       <= wdog_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_bits_q <= frame_bits_d;
      frame_qp_q   <= frame_qp_d;
      qp_q         <= qp_d;
      qp_vld_q     <= qp_vld_d;
      rc_start_q   <= rc_start_d;
      sys_done_q   <= sys_done_d;
      err_q        <= err_d;
      first_q      <= first_d;
    end
  end

  assign sys_done_o   = sys_done_q;
  assign qp_vld_o     = qp_vld_q;
  assign qp_o         = qp_q;
  assign rc_start_o   = rc_start_q;
  assign rc_ctu_x_o   = x_q;
  assign rc_ctu_y_o   = y_q;
  assign frame_qp_o   = frame_qp_q;
  assign frame_bits_o = frame_bits_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_rc_frame_ctrl.sv
// tb/tb_rc_frame_ctrl.sv - directed self-checking bench for rc_frame_ctrl
module tb_rc_frame_ctrl;

  localparam int WDOG_MAX = 31;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sys_start_i;
  logic [7:0]  sys_ctu_all_x_i, sys_ctu_all_y_i;
  logic        sys_done_o;
  logic        qp_req_i;
  logic        qp_vld_o;
  logic [5:0]  qp_o;
  logic        rc_start_o;
  logic [7:0]  rc_ctu_x_o, rc_ctu_y_o;
  logic        rc_done_i;
  logic [5:0]  rc_qp_i;
  logic        cabac_bit_vld_i;
  logic [15:0] cabac_bitnum_i;
  logic [31:0] reg_bitnum_i;
  logic [5:0]  reg_initial_qp, reg_max_qp, reg_min_qp;
  logic        reg_frame_rc_en;
  logic [5:0]  frame_qp_o;
  logic [31:0] frame_bits_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rc_frame_ctrl #(.PIC_X_WIDTH(8), .PIC_Y_WIDTH(8), .WDOG_MAX(WDOG_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .sys_start_i(sys_start_i), .sys_ctu_all_x_i(sys_ctu_all_x_i), .sys_ctu_all_y_i(sys_ctu_all_y_i),
    .sys_done_o(sys_done_o), .qp_req_i(qp_req_i), .qp_vld_o(qp_vld_o), .qp_o(qp_o),
    .rc_start_o(rc_start_o), .rc_ctu_x_o(rc_ctu_x_o), .rc_ctu_y_o(rc_ctu_y_o),
    .rc_done_i(rc_done_i), .rc_qp_i(rc_qp_i),
    .cabac_bit_vld_i(cabac_bit_vld_i), .cabac_bitnum_i(cabac_bitnum_i),
    .reg_bitnum_i(reg_bitnum_i), .reg_initial_qp(reg_initial_qp), .reg_max_qp(reg_max_qp),
    .reg_min_qp(reg_min_qp), .reg_frame_rc_en(reg_frame_rc_en),
    .frame_qp_o(frame_qp_o), .frame_bits_o(frame_bits_o), .err_o(err_o)
  );

  task automatic start_frame(input logic [7:0] ax, input logic [7:0] ay);
    @(posedge clk); #1;
    sys_ctu_all_x_i = ax;
    sys_ctu_all_y_i = ay;
    sys_start_i     = 1'b1;
    @(posedge clk); #1;
    sys_start_i     = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] b);
    @(posedge clk); #1;
    cabac_bit_vld_i = 1'b1;
    cabac_bitnum_i  = b;
    @(posedge clk); #1;
    cabac_bit_vld_i = 1'b0;
  endtask

  // One CTU handshake; lat counts negedges from rc_start_o to qp_vld_o.
  task automatic do_ctu(input logic [5:0] rqp, input bit send_done, input bit with_bits,
                        input logic [15:0] bits, output bit ok, output logic [5:0] qp,
                        output logic [7:0] x, output logic [7:0] y, output int starts,
                        output int lat);
    ok = 1'b0; qp = '0; x = '0; y = '0; starts = 0; lat = 0;
    qp_req_i = 1'b1;
    for (int i = 0; i < 20 && starts == 0; i++) begin
      @(negedge clk);
      if (rc_start_o) begin
        starts++;
        x = rc_ctu_x_o;
        y = rc_ctu_y_o;
      end
    end
    if (starts != 0) begin
      if (send_done) begin
        @(posedge clk); #1;
        rc_done_i = 1'b1;
        rc_qp_i   = rqp;
        if (with_bits) begin
          cabac_bit_vld_i = 1'b1;
          cabac_bitnum_i  = bits;
        end
        @(posedge clk); #1;
        rc_done_i       = 1'b0;
        cabac_bit_vld_i = 1'b0;
      end
      for (int i = 0; i < WDOG_MAX + 10 && !ok; i++) begin
        @(negedge clk);
        lat++;
        if (rc_start_o) starts++;
        if (qp_vld_o) begin
          ok = 1'b1;
          qp = qp_o;
        end
      end
      @(posedge clk); #1;
    end
    qp_req_i = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit seen, output int pulses);
    seen = 1'b0; pulses = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (sys_done_o) begin
        seen = 1'b1;
        pulses++;
      end
    end
  endtask

  task automatic serve_frame(input int n, output int served);
    bit ok; logic [5:0] qp; logic [7:0] x, y; int st, lat;
    served = 0;
    for (int i = 0; i < n; i++) begin
      do_ctu(6'd30, 1'b1, 1'b0, 16'd0, ok, qp, x, y, st, lat);
      if (ok) served++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (qp_o !== 6'd0 || qp_vld_o !== 1'b0) begin errors++; $display("FAIL reset_qp qp=%0d vld=%0b expected 0 0", qp_o, qp_vld_o); end
    checks++; if (rc_start_o !== 1'b0 || sys_done_o !== 1'b0) begin errors++; $display("FAIL reset_pulses start=%0b done=%0b expected 0 0", rc_start_o, sys_done_o); end
    checks++; if (rc_ctu_x_o !== 8'd0 || rc_ctu_y_o !== 8'd0) begin errors++; $display("FAIL reset_pos x=%0d y=%0d expected 0 0", rc_ctu_x_o, rc_ctu_y_o); end
    checks++; if (frame_qp_o !== 6'd0 || frame_bits_o !== 32'd0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_frame qp=%0d bits=%0d err=%0b expected 0 0 0", frame_qp_o, frame_bits_o, err_o); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_qp_sequence();
    logic [5:0] exp_qp [4] = '{6'd30, 6'd31, 6'd32, 6'd33};
    logic [7:0] exp_x  [4] = '{8'd0, 8'd1, 8'd0, 8'd1};
    logic [7:0] exp_y  [4] = '{8'd0, 8'd0, 8'd1, 8'd1};
    bit ok, seen; logic [5:0] qp; logic [7:0] x, y; int st, lat, pulses;
    reg_initial_qp = 6'd32; reg_max_qp = 6'd51; reg_min_qp = 6'd0;
    reg_frame_rc_en = 1'b1; reg_bitnum_i = 32'd4000;
    start_frame(8'd1, 8'd1);
    checks++; if (frame_qp_o !== 6'd32) begin errors++; $display("FAIL seq_init_qp got=%0d expected 32", frame_qp_o); end
    for (int i = 0; i < 4; i++) begin
      do_ctu(exp_qp[i], 1'b1, 1'b0, 16'd0, ok, qp, x, y, st, lat);
      checks++; if (!ok || qp !== exp_qp[i]) begin errors++; $display("FAIL seq_qp%0d ok=%0b got=%0d expected %0d", i, ok, qp, exp_qp[i]); end
      checks++; if (x !== exp_x[i] || y !== exp_y[i]) begin errors++; $display("FAIL seq_pos%0d got=(%0d,%0d) expected (%0d,%0d)", i, x, y, exp_x[i], exp_y[i]); end
      checks++; if (st != 1) begin errors++; $display("FAIL seq_starts%0d got=%0d expected 1", i, st); end
    end
    for (int i = 0; i < 4; i++) send_bits(16'd1500);
    wait_done(10, seen, pulses);
    checks++; if (!seen || pulses != 1) begin errors++; $display("FAIL seq_done pulses=%0d expected 1", pulses); end
    checks++; if (frame_bits_o !== 32'd6000) begin errors++; $display("FAIL seq_bits got=%0d expected 6000", frame_bits_o); end
    checks++; if (frame_qp_o !== 6'd33) begin errors++; $display("FAIL seq_qp_up got=%0d expected 33", frame_qp_o); end
  endtask

  task automatic test_min_clip();
    bit seen; int pulses, served;
    reg_initial_qp = 6'd20; reg_min_qp = 6'd20; reg_frame_rc_en = 1'b0;
    start_frame(8'd1, 8'd1);
    reg_frame_rc_en = 1'b1;
    checks++; if (frame_qp_o !== 6'd20) begin errors++; $display("FAIL min_load got=%0d expected 20", frame_qp_o); end
    serve_frame(4, served);
    checks++; if (served != 4) begin errors++; $display("FAIL min_served got=%0d expected 4", served); end
    for (int i = 0; i < 4; i++) send_bits(16'd500);
    wait_done(10, seen, pulses);
    checks++; if (!seen || frame_bits_o !== 32'd2000) begin errors++; $display("FAIL min_done seen=%0b bits=%0d expected 1 2000", seen, frame_bits_o); end
    checks++; if (frame_qp_o !== 6'd20) begin errors++; $display("FAIL min_clip got=%0d expected 20", frame_qp_o); end
  endtask

  task automatic test_max_clip();
    bit seen; int pulses, served;
    reg_min_qp = 6'd0; reg_initial_qp = 6'd40; reg_max_qp = 6'd40; reg_frame_rc_en = 1'b0;
    start_frame(8'd1, 8'd1);
    reg_frame_rc_en = 1'b1;
    serve_frame(4, served);
    for (int i = 0; i < 4; i++) send_bits(16'd1500);
    wait_done(10, seen, pulses);
    checks++; if (!seen || frame_qp_o !== 6'd40) begin errors++; $display("FAIL max_clip seen=%0b got=%0d expected 40", seen, frame_qp_o); end
  endtask

  task automatic test_decrement_and_band();
    bit seen; int pulses, served;
    reg_max_qp = 6'd51; reg_initial_qp = 6'd10;
    start_frame(8'd1, 8'd1);
    checks++; if (frame_qp_o !== 6'd40) begin errors++; $display("FAIL dec_keep got=%0d expected 40", frame_qp_o); end
    serve_frame(4, served);
    for (int i = 0; i < 4; i++) send_bits(16'd500);
    wait_done(10, seen, pulses);
    checks++; if (!seen || frame_qp_o !== 6'd39) begin errors++; $display("FAIL dec_qp seen=%0b got=%0d expected 39", seen, frame_qp_o); end
    start_frame(8'd1, 8'd1);
    serve_frame(4, served);
    for (int i = 0; i < 4; i++) send_bits(16'd1000);
    wait_done(10, seen, pulses);
    checks++; if (!seen || frame_qp_o !== 6'd39) begin errors++; $display("FAIL band_qp seen=%0b got=%0d expected 39", seen, frame_qp_o); end
  endtask

  task automatic test_watchdog();
    bit ok, seen; logic [5:0] qp; logic [7:0] x, y; int st, lat, pulses;
    start_frame(8'd0, 8'd0);
    do_ctu(6'd5, 1'b0, 1'b0, 16'd0, ok, qp, x, y, st, lat);
    checks++; if (!ok || qp !== 6'd39) begin errors++; $display("FAIL wdog_qp ok=%0b got=%0d expected 39", ok, qp); end
    checks++; if (lat != WDOG_MAX + 1) begin errors++; $display("FAIL wdog_lat got=%0d expected %0d", lat, WDOG_MAX + 1); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL wdog_err got=%0b expected 1", err_o); end
    send_bits(16'd100);
    wait_done(10, seen, pulses);
    checks++; if (!seen || pulses != 1 || frame_qp_o !== 6'd38) begin errors++; $display("FAIL wdog_single_done pulses=%0d qp=%0d expected 1 38", pulses, frame_qp_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL wdog_sticky got=%0b expected 1", err_o); end
  endtask

  task automatic test_late_bits();
    bit ok, seen; logic [5:0] qp; logic [7:0] x, y; int st, lat, pulses;
    send_bits(16'd777);
    checks++; if (frame_bits_o !== 32'd100) begin errors++; $display("FAIL idle_bits got=%0d expected 100", frame_bits_o); end
    start_frame(8'd1, 8'd1);
    for (int i = 0; i < 3; i++) do_ctu(6'd30, 1'b1, 1'b1, 16'd300, ok, qp, x, y, st, lat);
    do_ctu(6'd30, 1'b1, 1'b0, 16'd0, ok, qp, x, y, st, lat);
    checks++; if (frame_bits_o !== 32'd900) begin errors++; $display("FAIL late_same_cycle got=%0d expected 900", frame_bits_o); end
    wait_done(6, seen, pulses);
    checks++; if (seen) begin errors++; $display("FAIL late_early_done got=%0b expected 0", seen); end
    send_bits(16'd300);
    wait_done(10, seen, pulses);
    checks++; if (!seen || pulses != 1) begin errors++; $display("FAIL late_done pulses=%0d expected 1", pulses); end
    checks++; if (frame_bits_o !== 32'd1200 || frame_qp_o !== 6'd37) begin errors++; $display("FAIL late_frame bits=%0d qp=%0d expected 1200 37", frame_bits_o, frame_qp_o); end
  endtask

  task automatic test_reset_mid_frame();
    bit seen_start;
    seen_start = 1'b0;
    start_frame(8'd1, 8'd1);
    qp_req_i = 1'b1;
    for (int i = 0; i < 20 && !seen_start; i++) begin
      @(negedge clk);
      if (rc_start_o) seen_start = 1'b1;
    end
    checks++; if (!seen_start) begin errors++; $display("FAIL mid_start got=0 expected 1"); end
    #1; rstn = 1'b0; qp_req_i = 1'b0;
    @(negedge clk);
    checks++; if (frame_qp_o !== 6'd0 || frame_bits_o !== 32'd0 || err_o !== 1'b0 || qp_o !== 6'd0) begin errors++; $display("FAIL mid_reset qp=%0d bits=%0d err=%0b qpo=%0d expected all 0", frame_qp_o, frame_bits_o, err_o, qp_o); end
    checks++; if (rc_start_o !== 1'b0 || rc_ctu_x_o !== 8'd0 || qp_vld_o !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl start=%0b x=%0d vld=%0b expected 0", rc_start_o, rc_ctu_x_o, qp_vld_o); end
    @(posedge clk); #1;
    rstn = 1'b1;
    reg_initial_qp = 6'd25; reg_frame_rc_en = 1'b1;
    start_frame(8'd0, 8'd0);
    checks++; if (frame_qp_o !== 6'd25) begin errors++; $display("FAIL mid_reload got=%0d expected 25", frame_qp_o); end
  endtask

  initial begin
    rstn = 1'b0; sys_start_i = 1'b0; sys_ctu_all_x_i = '0; sys_ctu_all_y_i = '0;
    qp_req_i = 1'b0; rc_done_i = 1'b0; rc_qp_i = '0;
    cabac_bit_vld_i = 1'b0; cabac_bitnum_i = '0; reg_bitnum_i = 32'd4000;
    reg_initial_qp = 6'd32; reg_max_qp = 6'd51; reg_min_qp = 6'd0; reg_frame_rc_en = 1'b1;
    test_reset();
    test_qp_sequence();
    test_min_clip();
    test_max_clip();
    test_decrement_and_band();
    test_watchdog();
    test_late_bits();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
